// File: rtl/spm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_pkg
// Description : Shared types and helpers for the spm_seq serial-parallel
//               multiplier: FSM state enum, counter-width function and the
//               default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_pkg;

   // Default operand width of the multiplier
   localparam int c_default_n = 8;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } spm_state_t;

   // Ceiling log2, used to size the bit counter for 2N serial steps
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spm_csa_cell.sv
`default_nettype none
// ============================================================================
// Module      : spm_csa_cell
// Description : One bit-slice of the serial-parallel multiplier array. Full
//               adder of the partial-product bit, the left neighbour's sum
//               and its own stored carry, with registered sum and carry.
//               TWOS_COMP=1 turns the slice into a serial complementer: the
//               partial-product bit is inverted and the carry presets to 1
//               on clear, so the slice emits the negated weight of the sign
//               bit of the multiplicand.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_csa_cell #(
   parameter bit TWOS_COMP = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_pp,
   input  logic i_sin,
   output logic o_sum
);

   logic w_a;
   logic w_sum;
   logic w_cout;
   logic r_sum;
   logic r_carry;

   assign w_a    = TWOS_COMP ? ~i_pp : i_pp;
   assign w_sum  = w_a ^ i_sin ^ r_carry;
   assign w_cout = (w_a & i_sin) | (w_a & r_carry) | (i_sin & r_carry);
   assign o_sum  = r_sum;

   // Sum/carry state: cleared (carry preset for the complementer) at the start
   // of each operation, advanced once per serial step
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum   <= 1'b0;
         r_carry <= 1'b0;
      end else if (i_clr) begin
         r_sum   <= 1'b0;
         r_carry <= TWOS_COMP;
      end else if (i_en) begin
         r_sum   <= w_sum;
         r_carry <= w_cout;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spm_seq.sv
`default_nettype none
// ============================================================================
// Module      : spm_seq
// Description : Signed NxN serial-parallel multiplier with start/busy/done
//               handshake. x is held in parallel across a carry-save array,
//               y is fed serially LSB first and sign-extended to 2N bits; the
//               2N-bit product is collected bit-serially and presented in
//               parallel. Latency 2N+1 cycles from the accepting edge.
//               Build option SPM_ACC_EN: adds acc_clr and accumulates
//               products into prod modulo 2^(2N).
// Revision    : 1.0 - initial release
// ============================================================================
module spm_seq
   import spm_pkg::*;
#(
   parameter int N = c_default_n
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   x,
   input  logic [N-1:0]   y,
`ifdef SPM_ACC_EN
   input  logic           acc_clr,
`endif
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] prod
);

   localparam int             c_cw   = clog2(2 * N);
   localparam logic [c_cw-1:0] c_last = c_cw'(2 * N - 1);
   localparam logic [c_cw-1:0] c_n    = c_cw'(N);
   localparam logic [c_cw-1:0] c_one  = c_cw'(1);

   spm_state_t          r_state;
   spm_state_t          w_next;

   logic [N-1:0]        r_x;
   logic [N-1:0]        r_y_sh;
   logic                r_ysign;
   logic [c_cw-1:0]     r_cnt;
   logic                r_c0;
   // Upper 2N-1 bits of the product shift window; the newest bit comes
   // straight from the LSB adder, so the full product is w_p_next on the
   // final step.
   logic [2*N-1:1]      r_p_sh;
   logic [2*N-1:0]      r_prod;
   logic                r_busy;
   logic                r_done;

   logic                w_accept;
   logic                w_run;
   logic                w_last;
   logic                w_bit;
   logic [N-1:0]        w_pp;
   logic [N-1:1]        w_s;
   logic                w_sum0;
   logic                w_c0;
   logic [2*N-1:0]      w_p_next;
   logic [2*N-1:0]      w_result;

   assign w_accept = start && ((r_state == IDLE) || (r_state == FIN));
   assign w_run    = (r_state == RUN);
   assign w_last   = w_run && (r_cnt == c_last);

   // Serial multiplier bit: y LSB first, then its sign bit for the upper half
   assign w_bit = (r_cnt < c_n) ? r_y_sh[0] : r_ysign;
   assign w_pp  = r_x & {N{w_bit}};

   // Bit-slices 1..N-1; the top slice negates the sign-bit partial products
   genvar gi;
   generate
      for (gi = 1; gi < N; gi++) begin : g_cell
         if (gi == N - 1) begin : g_msb
            spm_csa_cell #(
               .TWOS_COMP (1'b1)
            ) u_cell (
               .clk   (clk),
               .rst   (rst),
               .i_clr (w_accept),
               .i_en  (w_run),
               .i_pp  (w_pp[gi]),
               .i_sin (1'b0),
               .o_sum (w_s[gi])
            );
         end else begin : g_mid
            spm_csa_cell #(
               .TWOS_COMP (1'b0)
            ) u_cell (
               .clk   (clk),
               .rst   (rst),
               .i_clr (w_accept),
               .i_en  (w_run),
               .i_pp  (w_pp[gi]),
               .i_sin (w_s[gi+1]),
               .o_sum (w_s[gi])
            );
         end
      end
   endgenerate

   // LSB slice: its sum is the product bit of the current step, so it feeds
   // the shift window combinationally; only its carry is stored
   assign w_sum0   = w_pp[0] ^ w_s[1] ^ r_c0;
   assign w_c0     = (w_pp[0] & w_s[1]) | (w_pp[0] & r_c0) | (w_s[1] & r_c0);
   assign w_p_next = {w_sum0, r_p_sh};

`ifdef SPM_ACC_EN
   logic r_acc_clr;

   // Capture the accumulator-clear request with the operands
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_clr <= 1'b0;
      end else if (w_accept) begin
         r_acc_clr <= acc_clr;
      end
   end

   assign w_result = r_acc_clr ? w_p_next : (r_prod + w_p_next);
`else
   assign w_result = w_p_next;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic; start during RUN is deliberately ignored
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (r_cnt == c_last) w_next = FIN;
         FIN:     w_next = start ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand capture and serial datapath stepping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x     <= '0;
         r_y_sh  <= '0;
         r_ysign <= 1'b0;
         r_cnt   <= '0;
         r_c0    <= 1'b0;
         r_p_sh  <= '0;
      end else if (w_accept) begin
         r_x     <= x;
         r_y_sh  <= y;
         r_ysign <= y[N-1];
         r_cnt   <= '0;
         r_c0    <= 1'b0;
         r_p_sh  <= '0;
      end else if (w_run) begin
         r_y_sh  <= {1'b0, r_y_sh[N-1:1]};
         r_cnt   <= r_cnt + c_one;
         r_c0    <= w_c0;
         r_p_sh  <= w_p_next[2*N-1:1];
      end
   end

   // Registered outputs: busy follows the next state, done and prod are
   // produced on the final serial step so they are valid together in FIN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_prod <= '0;
      end else begin
         r_busy <= (w_next == RUN);
         r_done <= w_last;
         if (w_last) begin
            r_prod <= w_result;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign prod = r_prod;

endmodule
`default_nettype wire

// File: tb/tb_spm_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_seq
// Description : Self-checking bench for spm_seq at N=8 (directed and random),
//               N=4 and N=16 (random and extremes). Expected products are
//               computed with plain signed integer arithmetic. Accumulate
//               scenarios are exercised when SPM_ACC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spm_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        acc_clr;

   logic        start8;
   logic [7:0]  x8, y8;
   logic        busy8, done8;
   logic [15:0] prod8;

   logic        start4;
   logic [3:0]  x4, y4;
   logic        busy4, done4;
   logic [7:0]  prod4;

   logic        start16;
   logic [15:0] x16, y16;
   logic        busy16, done16;
   logic [31:0] prod16;

`ifdef SPM_ACC_EN
   logic        one = 1'b1;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [15:0] m_acc8;

   always #5 clk = ~clk;

   spm_seq #(.N(8)) dut8 (
      .clk     (clk),
      .rst     (rst),
      .start   (start8),
      .x       (x8),
      .y       (y8),
`ifdef SPM_ACC_EN
      .acc_clr (acc_clr),
`endif
      .busy    (busy8),
      .done    (done8),
      .prod    (prod8)
   );

   spm_seq #(.N(4)) dut4 (
      .clk     (clk),
      .rst     (rst),
      .start   (start4),
      .x       (x4),
      .y       (y4),
`ifdef SPM_ACC_EN
      .acc_clr (one),
`endif
      .busy    (busy4),
      .done    (done4),
      .prod    (prod4)
   );

   spm_seq #(.N(16)) dut16 (
      .clk     (clk),
      .rst     (rst),
      .start   (start16),
      .x       (x16),
      .y       (y16),
`ifdef SPM_ACC_EN
      .acc_clr (one),
`endif
      .busy    (busy16),
      .done    (done16),
      .prod    (prod16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact signed product, then the accumulate rule if enabled
   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic clr);
      logic [15:0] p;
      p = 16'(longint'($signed(a)) * longint'($signed(b)));
`ifdef SPM_ACC_EN
      return clr ? p : 16'(m_acc8 + p);
`else
      return p;
`endif
   endfunction

   // One N=8 operation; optionally pokes start during RUN
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic clr,
                      input bit poke, input string tag);
      logic [15:0] exp;
      int nbusy, ndone;
      exp = model8(a, b, clr);
      m_acc8 = exp;
      @(negedge clk);
      start8 = 1'b1; x8 = a; y8 = b; acc_clr = clr;
      @(negedge clk);
      start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); acc_clr = 1'($urandom);
      nbusy = 0; ndone = 0;
      for (int c = 1; c <= 16; c++) begin
         if (busy8) nbusy++;
         if (done8) ndone++;
         if (poke && c == 5) begin
            start8 = 1'b1; x8 = 8'($urandom); y8 = 8'($urandom);
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 64'(nbusy), 64'd16);
      check({tag, "_early_done"}, 64'(ndone), 64'd0);
      check({tag, "_done"}, {63'd0, done8}, 64'd1);
      check({tag, "_busy_in_fin"}, {63'd0, busy8}, 64'd0);
      check({tag, "_prod"}, {48'd0, prod8}, {48'd0, exp});
      @(negedge clk);
      check({tag, "_done_pulse"}, {63'd0, done8}, 64'd0);
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] exp;
      int c;
      exp = 8'(longint'($signed(a)) * longint'($signed(b)));
      @(negedge clk);
      start4 = 1'b1; x4 = a; y4 = b;
      @(negedge clk);
      start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom);
      c = 1;
      while (!done4 && c < 40) begin
         @(negedge clk);
         c++;
      end
      check("n4_latency", 64'(c), 64'd9);
      check("n4_prod", {56'd0, prod4}, {56'd0, exp});
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] exp;
      int c;
      exp = 32'(longint'($signed(a)) * longint'($signed(b)));
      @(negedge clk);
      start16 = 1'b1; x16 = a; y16 = b;
      @(negedge clk);
      start16 = 1'b0; x16 = 16'($urandom); y16 = 16'($urandom);
      c = 1;
      while (!done16 && c < 80) begin
         @(negedge clk);
         c++;
      end
      check("n16_latency", 64'(c), 64'd33);
      check("n16_prod", {32'd0, prod16}, {32'd0, exp});
   endtask

   initial begin
      int nd;
      logic [15:0] e1, e2;
      rst = 1'b1; acc_clr = 1'b1; m_acc8 = '0;
      start8 = 1'b0; x8 = '0; y8 = '0;
      start4 = 1'b0; x4 = '0; y4 = '0;
      start16 = 1'b0; x16 = '0; y16 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy8}, 64'd0);
      check("rst_done", {63'd0, done8}, 64'd0);
      check("rst_prod", {48'd0, prod8}, 64'd0);
      check("rst_prod4", {56'd0, prod4}, 64'd0);
      check("rst_prod16", {32'd0, prod16}, 64'd0);
      rst = 1'b0;

      // Directed N=8 cases
      op8(8'd3, 8'd5, 1'b1, 1'b0, "p3x5");
      check("p3x5_value", {48'd0, prod8}, 64'd15);
      op8(8'h80, 8'h80, 1'b1, 1'b0, "min_min");
      check("min_min_value", {48'd0, prod8}, 64'd16384);
      op8(8'h80, 8'h7F, 1'b1, 1'b0, "min_max");
      check("min_max_value", {48'd0, prod8}, {48'd0, 16'hC080});
      op8(8'hFF, 8'hFF, 1'b1, 1'b0, "m1_m1");
      op8(8'h00, 8'hB3, 1'b1, 1'b0, "zero_x");
      op8(8'h25, 8'hC9, 1'b1, 1'b1, "poke_run");

      // Back-to-back: start held through FIN
      @(negedge clk);
      start8 = 1'b1; x8 = 8'd7; y8 = 8'hF7; acc_clr = 1'b1;
      @(negedge clk);
      x8 = 8'h9C; y8 = 8'd55;
      nd = 0;
      for (int c = 1; c <= 16; c++) begin
         if (done8) nd++;
         @(negedge clk);
      end
      e1 = 16'hFFC1;
      e2 = 16'hEA84;
      check("b2b_done1", {63'd0, done8}, 64'd1);
      check("b2b_prod1", {48'd0, prod8}, {48'd0, e1});
      @(negedge clk);
      start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
      for (int c = 1; c <= 16; c++) begin
         if (done8) nd++;
         @(negedge clk);
      end
      check("b2b_gap_done", 64'(nd), 64'd0);
      check("b2b_done2", {63'd0, done8}, 64'd1);
      check("b2b_prod2", {48'd0, prod8}, {48'd0, e2});
      m_acc8 = e2;
      @(negedge clk);

      // Reset in the middle of RUN
      @(negedge clk);
      start8 = 1'b1; x8 = 8'd50; y8 = 8'hFD;
      @(negedge clk);
      start8 = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {63'd0, busy8}, 64'd0);
      check("abort_done", {63'd0, done8}, 64'd0);
      check("abort_prod", {48'd0, prod8}, 64'd0);
      rst = 1'b0;
      m_acc8 = '0;
      nd = 0;
      for (int c = 0; c < 30; c++) begin
         if (done8 || busy8) nd++;
         @(negedge clk);
      end
      check("abort_no_done", 64'(nd), 64'd0);

`ifdef SPM_ACC_EN
      op8(8'd10, 8'd10, 1'b1, 1'b0, "acc_first");
      check("acc_first_value", {48'd0, prod8}, 64'd100);
      op8(8'hFD, 8'd4, 1'b0, 1'b0, "acc_second");
      check("acc_second_value", {48'd0, prod8}, 64'd88);
`endif

      // Random N=8
      for (int i = 0; i < 40; i++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), "rnd8");
      end

      // N=4 extremes and random
      op4(4'h8, 4'h8);
      op4(4'h8, 4'h7);
      op4(4'hF, 4'hF);
      for (int i = 0; i < 25; i++) begin
         op4(4'($urandom), 4'($urandom));
      end

      // N=16 extremes and random
      op16(16'h8000, 16'h8000);
      op16(16'h8000, 16'h7FFF);
      op16(16'hFFFF, 16'h0001);
      for (int i = 0; i < 25; i++) begin
         op16(16'($urandom), 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/spm_seq.md
# spm_seq

Parametrised signed N×N serial-parallel multiplier with start/busy/done handshake. The multiplicand x is held in parallel across a chain of carry-save cells. The multiplier y is shifted in serially, LSB first and sign-extended. The 2N-bit product is assembled bit-serially and presented in parallel. It replaces the fixed 8-bit free-running multiplier in the arithmetic datapath, and adds operand capture, sequencing and completion signalling.

## Interface
- N, default 8: operand width in bits; legal N ≥ 2.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only when the block is not busy.
- x  in  N  signed multiplicand; sampled on the accepting edge.
- y  in  N  signed multiplier; sampled on the accepting edge.
- acc_clr  in  1  present only with SPM_ACC_EN; sampled with start.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  one-cycle pulse when prod is updated.
- prod  out  2N  signed result; holds until the next done.

## Operation
- FSM states: IDLE, RUN, FIN.
  - IDLE → RUN on start.
  - RUN → FIN when cnt == 2N−1.
  - FIN → RUN if start is high in FIN; otherwise FIN → IDLE.
- Accepting edge (start high in IDLE or FIN):
  - x_reg ← x; y_sh ← y; cnt ← 0.
  - All CSA sum/carry flops ← 0; p_sh ← 0.
- RUN, each cycle:
  - The serial bit is y_sh[0] for cnt < N, and y_reg sign bit y[N−1] for cnt ≥ N (sign extension).
  - Cell i adds x_reg[i]&bit, its stored carry, and the sum of its left neighbour.
  - The MSB cell uses two's-complement weighting of x_reg[N−1]&bit: the serial complementer is preset with carry-in 1 on the accepting edge.
  - The LSB cell sum shifts into p_sh[2N−1] while p_sh shifts right; y_sh shifts right.
  - cnt increments.
- Arithmetic: prod equals the exact signed product x·y in 2N bits. No overflow is possible, including −2^(N−1)·−2^(N−1) = 2^(2N−2).
- FIN cycle:
  - prod ← p_sh; done = 1; busy = 0.
  - A new start may be accepted in this same cycle, giving back-to-back operation.
- start while in RUN is ignored: no queueing, no error.
- x and y may change freely after the accepting edge.
- Reset mid-RUN:
  - FSM returns to IDLE; all flops, busy, done and prod return to 0.
  - No done is produced for the aborted operation.

## Timing
- Reset values: busy = 0, done = 0, prod = 0, state = IDLE.
- Suppose start is high at edge k.
  - busy = 1 for cycles k+1 through k+2N.
  - done = 1 and prod is valid in cycle k+2N+1. Latency is 2N+1 cycles, i.e. 17 for N = 8.
- Throughput: one result per 2N+1 cycles when start is held high.
- busy and done are never high in the same cycle.
- All outputs are registered.

## Configuration
- SPM_ACC_EN defined:
  - The acc_clr port exists.
  - In FIN, prod ← prod + product modulo 2^(2N).
  - If acc_clr was high on the accepting edge, prod ← product for that operation.
  - Reset still clears prod.
- SPM_ACC_EN undefined:
  - There is no acc_clr port.
  - prod ← product every operation.

## Structure
- Shared package spm_pkg holds:
  - the state enum {IDLE, RUN, FIN};
  - the cnt width function clog2(2N);
  - default N.
- One sub-module, spm_csa_cell: a 1-bit full adder with registered sum and carry, plus a clear input.
  - It is instantiated N−1 times in a generate loop.
  - The MSB cell instance carries a parameter selecting two's-complement carry preset.

## Test plan
- N = 8, reset, then x = 3, y = 5, start for one cycle:
  - busy high for 16 cycles;
  - done in cycle 17 with prod = 15.
- x = −128, y = −128 → prod = 16384.
- x = −128, y = 127 → prod = −16256.
- x = −1, y = −1 → prod = 1.
- x = 0, y = −77 → prod = 0.
- start held high with operand pairs (7, −9) then (−100, 55):
  - two done pulses 17 cycles apart;
  - prod = −63, then −5500.
- start pulsed during RUN: ignored, result unchanged.
- rst asserted at cycle 8 of RUN:
  - all outputs 0;
  - no done.
- With SPM_ACC_EN, first start with acc_clr = 1 and (10, 10), then (−3, 4) with acc_clr = 0:
  - prod = 100, then 88.
- Random signed pairs checked against x·y for N = 8, and with N = 4 and N = 16.
